// File: rtl/tm_out_vector_capture_if.sv
// Vector/response bus between the netlist-facing capture block and its consumer.
// The slave view belongs to the capture block. The master view belongs to the environment.
interface tm_out_vector_capture_if #(
    parameter int WIDTH = 62,
    parameter int HD_W  = 7
);
    logic [WIDTH-1:0] vec_in;
    logic             vec_valid;
    logic [WIDTH-1:0] out_data;
    logic [HD_W-1:0]  out_hd;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output vec_in, vec_valid, out_ready,
        input  out_data, out_hd, out_valid
    );

    modport slave (
        input  vec_in, vec_valid, out_ready,
        output out_data, out_hd, out_valid
    );
endinterface

// File: rtl/tm_out_vector_capture.sv
// Response capture for gate-level power characterisation: samples the netlist output
// vector, tracks toggle statistics per run and queues {vector, hamming distance} for a consumer.
module tm_out_vector_capture #(
    parameter int WIDTH   = 62,
    parameter int DEPTH   = 16,
    parameter int NUM_VEC = 1000,
    parameter int CNT_W   = 32,
    parameter int HD_W    = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    tm_out_vector_capture_if.slave vec_bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [CNT_W-1:0]       vec_count,
    output logic [CNT_W-1:0]       toggle_total
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN, ST_DONE} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [HD_W-1:0]  mem_hd   [DEPTH];
    logic [PTR_W:0]   rd_ptr, wr_ptr, fill;
    logic             empty, full, pop, push, sample, clear_run;
    logic [WIDTH-1:0] prev;
    logic             first;
    logic [HD_W-1:0]  hd;

    function automatic logic [HD_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [HD_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + HD_W'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [HD_W-1:0]  b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign fill   = wr_ptr - rd_ptr;
    assign empty  = (fill == '0);
    assign full   = (fill == (PTR_W+1)'(DEPTH));
    assign pop    = !empty && vec_bus.out_ready;
    assign sample = (state == ST_CAPTURE) && vec_bus.vec_valid;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push   = sample && (!full || pop);
    assign hd     = first ? '0 : popcount(vec_bus.vec_in ^ prev);

    assign vec_bus.out_valid = !empty;
    assign vec_bus.out_data  = empty ? '0 : mem_data[rd_ptr[PTR_W-1:0]];
    assign vec_bus.out_hd    = empty ? '0 : mem_hd[rd_ptr[PTR_W-1:0]];
    assign busy = (state == ST_CAPTURE) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    always_comb begin
        state_next = state;
        clear_run  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_CAPTURE;
                    clear_run  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (sample && vec_count == CNT_W'(NUM_VEC - 1)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (empty) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            prev         <= '0;
            first        <= 1'b1;
            vec_count    <= '0;
            toggle_total <= '0;
            overflow     <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
        end else begin
            state <= state_next;
            if (clear_run) begin
                prev         <= '0;
                first        <= 1'b1;
                vec_count    <= '0;
                toggle_total <= '0;
                overflow     <= 1'b0;
            end else if (sample) begin
                prev         <= vec_bus.vec_in;
                first        <= 1'b0;
                vec_count    <= vec_count + CNT_W'(1);
                toggle_total <= sat_add(toggle_total, hd);
                if (!push) overflow <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[PTR_W-1:0]] <= vec_bus.vec_in;
            mem_hd[wr_ptr[PTR_W-1:0]]   <= hd;
        end
    end
endmodule

// File: tb/tb_tm_out_vector_capture.sv
// Bench for tm_out_vector_capture: table-driven basic run, hand-written corner sequences
// and randomized runs, all checked against a queue-based reference model.
module tb_tm_out_vector_capture;
    localparam int W  = 62;
    localparam int D  = 16;
    localparam int NV = 20;
    localparam int CW = 32;
    localparam int HW = 7;
    localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, overflow;
    logic [CW-1:0] vec_count, toggle_total;

    tm_out_vector_capture_if #(.WIDTH(W), .HD_W(HW)) bus ();

    tm_out_vector_capture #(
        .WIDTH(W), .DEPTH(D), .NUM_VEC(NV), .CNT_W(CW), .HD_W(HW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vec_bus(bus),
        .busy(busy), .done(done), .overflow(overflow),
        .vec_count(vec_count), .toggle_total(toggle_total)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] v; int hd; } ent_t;
    typedef struct { logic [W-1:0] vec; int exp_hd; } vec_rec_t;

    ent_t            mq[$];
    int              m_state;
    logic [W-1:0]    m_prev;
    bit              m_first;
    longint unsigned m_cnt, m_tot;
    bit              m_ovf;
    int              checks = 0;
    int              errors = 0;
    vec_rec_t        tbl[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = M_IDLE;
        m_prev  = '0;
        m_first = 1'b1;
        m_cnt   = 0;
        m_tot   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_update(input bit st, input bit vv, input logic [W-1:0] v, input bit rdy);
        bit   was_empty, smp;
        int   h;
        ent_t e;
        was_empty = (mq.size() == 0);
        smp = (m_state == M_CAP) && vv;
        h = 0;
        if (smp && !m_first) h = $countones(v ^ m_prev);
        if (!was_empty && rdy) void'(mq.pop_front());
        if (smp) begin
            if (mq.size() < D) begin
                e.v = v; e.hd = h;
                mq.push_back(e);
            end else m_ovf = 1'b1;
            m_prev  = v;
            m_first = 1'b0;
            m_cnt   = m_cnt + 1;
            m_tot   = m_tot + longint'(h);
            if (m_tot > 64'hFFFF_FFFF) m_tot = 64'hFFFF_FFFF;
        end
        case (m_state)
            M_IDLE, M_DONE: if (st) begin
                m_state = M_CAP; m_cnt = 0; m_tot = 0; m_ovf = 1'b0;
                m_prev = '0; m_first = 1'b1;
            end
            M_CAP:   if (smp && m_cnt == NV) m_state = M_DRAIN;
            M_DRAIN: if (was_empty) m_state = M_DONE;
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_data", 64'(bus.out_data), 64'(mq[0].v));
            check("out_hd", 64'(bus.out_hd), 64'(mq[0].hd));
        end
        check("busy", 64'(busy), 64'(m_state == M_CAP || m_state == M_DRAIN));
        check("done", 64'(done), 64'(m_state == M_DONE));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("vec_count", 64'(vec_count), m_cnt);
        check("toggle_total", 64'(toggle_total), m_tot);
    endtask

    task automatic step(input bit st, input bit vv, input logic [W-1:0] v, input bit rdy);
        start         = st;
        bus.vec_valid = vv;
        bus.vec_in    = v;
        bus.out_ready = rdy;
        @(posedge clk);
        model_update(st, vv, v, rdy);
        #1;
        compare_all();
    endtask

    task automatic drain_until_done();
        for (int k = 0; k < 100 && !done; k++) step(1'b0, 1'b0, '0, 1'b1);
        check("drain_done", 64'(done), 64'(1));
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic random_run(input logic [W-1:0] last_vec);
        step(1'b1, 1'b0, '0, 1'b1);
        for (int k = 0; k < 400 && m_state == M_CAP; k++) begin
            logic [W-1:0] v;
            bit vv;
            vv = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 4) == 0) ? m_prev : rand_vec();
            if (vv && m_cnt == NV - 1) v = last_vec;
            step($urandom_range(0, 9) == 0, vv, v, $urandom_range(0, 2) != 0);
        end
        check("run_reached_drain", 64'(busy && vec_count == NV), 64'(1));
        drain_until_done();
    endtask

    initial begin
        int pops;
        bus.vec_in = '0; bus.vec_valid = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_out_data", 64'(bus.out_data), 64'(0));
        check("reset_out_hd", 64'(bus.out_hd), 64'(0));
        rst = 1'b1;

        // Basic run with explicit Hamming distances
        tbl[0] = '{62'h0, 0};
        tbl[1] = '{62'h3, 2};
        tbl[2] = '{62'h0, 2};
        tbl[3] = '{62'h3FFF_FFFF_FFFF_FFFF, 62};
        for (int i = 4; i < NV; i++) tbl[i] = '{62'h3FFF_FFFF_FFFF_FFFF, 0};
        step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < NV; i++) begin
            step(1'b0, 1'b1, tbl[i].vec, 1'b1);
            check("basic_hd", 64'(bus.out_hd), 64'(tbl[i].exp_hd));
            check("basic_head", 64'(bus.out_data), 64'(tbl[i].vec));
        end
        check("basic_total", 64'(toggle_total), 64'(66));
        check("basic_count", 64'(vec_count), 64'(NV));
        step(1'b0, 1'b0, '0, 1'b1);
        check("basic_done_t1", 64'(done), 64'(0));
        step(1'b0, 1'b0, '0, 1'b1);
        check("basic_done_t2", 64'(done), 64'(1));

        // Backpressure: 20 samples into a 16-entry FIFO
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < NV; i++) step(1'b0, 1'b1, W'(i + 1), 1'b0);
        check("bp_overflow", 64'(overflow), 64'(1));
        check("bp_count", 64'(vec_count), 64'(NV));
        pops = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (bus.out_valid) begin
                check("bp_order", 64'(bus.out_data), 64'(pops + 1));
                pops++;
            end
            step(1'b0, 1'b0, '0, 1'b1);
        end
        check("bp_pops", 64'(pops), 64'(D));
        check("bp_done", 64'(done), 64'(1));

        // Full FIFO with simultaneous push and pop
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, W'(100 + i), 1'b0);
        step(1'b0, 1'b1, W'(100 + D), 1'b1);
        check("fpp_overflow", 64'(overflow), 64'(0));
        pops = 0;
        for (int k = 0; k < D; k++) begin
            if (bus.out_valid) begin
                check("fpp_order", 64'(bus.out_data), 64'(101 + pops));
                pops++;
            end
            step(1'b0, 1'b0, '0, 1'b1);
        end
        check("fpp_pops", 64'(pops), 64'(D));
        check("fpp_empty", 64'(bus.out_valid), 64'(0));
        for (int i = 0; i < NV - D - 1; i++) step(1'b0, 1'b1, rand_vec(), 1'b1);
        drain_until_done();

        // Mid-run asynchronous reset
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rand_vec(), 1'b0);
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("mrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mrst_count", 64'(vec_count), 64'(0));
        check("mrst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // start pulse during capture is ignored
        step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand_vec(), 1'b1);
        step(1'b1, 1'b1, rand_vec(), 1'b1);
        check("start_ignored", 64'(vec_count), 64'(4));
        for (int i = 0; i < NV - 4; i++) step(1'b0, 1'b1, rand_vec(), 1'b1);
        drain_until_done();

        // Random run ending on 0xFF, then restart with 0x00
        random_run(62'hFF);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, '0, 1'b1);
        check("restart_hd", 64'(bus.out_hd), 64'(0));
        check("restart_count", 64'(vec_count), 64'(1));
        check("restart_total", 64'(toggle_total), 64'(0));
        for (int i = 0; i < NV - 1; i++) step(1'b0, 1'b1, rand_vec(), $urandom_range(0, 1) != 0);
        drain_until_done();
        random_run(rand_vec());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tm_out_vector_capture.md
Name: tm_out_vector_capture

Overview:
- Response-capture block for the gate-level power-characterisation flow. It is the reading end of the vector interface: the stimulus side drives one input vector per clock into the netlist under test, and this block samples the netlist's output vector on each clock.
- For each sample it computes the Hamming distance (toggle count) to the previous sample and keeps run statistics.
- Captured samples and their Hamming distances go into a FIFO that a valid/ready consumer drains (logger or signature unit).

Parameters:
WIDTH, 62, output-vector width (out0..out61 packed, out0 = bit 0)
DEPTH, 16, FIFO entries; power of two, >= 2
NUM_VEC, 1000, samples per capture run
CNT_W, 32, width of the statistics counters
HD_W, 7, Hamming-distance width; must satisfy 2^HD_W > WIDTH

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
vec_in  in  WIDTH  netlist output vector
vec_valid  in  1  vec_in is sampled this cycle
out_data  out  WIDTH  FIFO head vector
out_hd  out  HD_W  FIFO head Hamming distance
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head
busy  out  1  state is CAPTURE or DRAIN
done  out  1  state is DONE
overflow  out  1  sticky: a sample was dropped because the FIFO was full
vec_count  out  CNT_W  samples taken this run
toggle_total  out  CNT_W  sum of Hamming distances this run

Behaviour:
- Reset (rst=0, async): state IDLE; FIFO empty; prev vector = 0; first-sample flag = 1. All outputs are 0 (out_data, out_hd, out_valid, busy, done, overflow, vec_count, toggle_total). Asserting reset mid-run aborts the run and discards FIFO contents.
- States:
  - IDLE -start-> CAPTURE
  - CAPTURE -(vec_count reaches NUM_VEC)-> DRAIN
  - DRAIN -(FIFO empty)-> DONE
  - DONE -start-> CAPTURE
- Run start: start in IDLE or DONE clears vec_count, toggle_total, overflow and prev vector, sets the first-sample flag, and leaves FIFO contents intact. start is ignored in CAPTURE and DRAIN.
- Sample: occurs in CAPTURE when vec_valid=1.
  - hd = popcount(vec_in XOR prev), except hd = 0 on the first sample of a run.
  - Registered updates: prev <= vec_in; first flag <= 0; vec_count += 1; toggle_total += hd, saturating at 2^CNT_W-1.
  - FIFO push of {vec_in, hd} if there is space, else the entry is dropped and overflow <= 1. Statistics update on a dropped sample too.
- The sample that makes vec_count equal NUM_VEC moves the state to DRAIN on the same edge. vec_valid is ignored outside CAPTURE.
- FIFO:
  - out_valid = not empty; out_data/out_hd show the head.
  - Pop on out_valid & out_ready.
  - Push at edge t is visible at the head from t+1 if the FIFO was empty (1-cycle latency).
  - Simultaneous push and pop when full: both succeed, count unchanged, no overflow.
  - Simultaneous push and pop when empty: only the push takes effect.
  - Read and write pointers wrap modulo DEPTH.
- The consumer may hold out_ready low for any time. out_data/out_hd stay stable while out_valid=1 and out_ready=0.
- DRAIN with an empty FIFO goes to DONE on the next edge. done stays 1 until start or reset. Statistics hold in DONE.

Test Plan:
- Basic: NUM_VEC=4, out_ready=1, vectors 0x0, 0x3, 0x0, 0x3FFFFFFFFFFFFFFF -> out_hd sequence 0, 2, 2, 62; toggle_total=66; vec_count=4; done=1 two cycles after the 4th sample.
- Backpressure/overflow: DEPTH=16, out_ready=0, 20 consecutive samples -> first 16 retained in order; overflow=1; vec_count=20; then out_ready=1 drains exactly 16 entries.
- Full push+pop: FIFO full, vec_valid=1 and out_ready=1 in the same cycle -> entry accepted, occupancy stays 16, overflow stays 0.
- Mid-run reset: rst low for 1 cycle after 5 samples -> out_valid=0, all counters 0, state IDLE; a following start and run of NUM_VEC samples completes normally.
- Restart: start in DONE with prev ending 0xFF -> next first sample 0x00 gives hd=0 (not 8); counters restart from 0.
- start pulse during CAPTURE -> ignored; vec_count continues without clearing.
